// File: rtl/ascon_rcon_seq.sv
// Ascon round-constant sequencer: p12/p8/p6, UNROLL constants per cycle,
// start/advance handshake with stall, last/done, abort and illegal-mode err.
module ascon_rcon_seq #(
   parameter int UNROLL = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [1:0]            nr,
   input  logic                  adv,
   input  logic                  clr,
   output logic [8*UNROLL-1:0]   cst,
   output logic                  busy,
   output logic                  last,
   output logic                  done,
   output logic                  err
);

   if (UNROLL != 1 && UNROLL != 2) begin : g_bad_unroll
      $error("ascon_rcon_seq: UNROLL must be 1 or 2");
   end

   typedef enum logic {IDLE, RUN} state_t;

   localparam logic [3:0] STEP = 4'(UNROLL);
   localparam logic [3:0] LAST_IDX = 4'd12;

   state_t     state;
   state_t     state_nxt;
   logic [3:0] idx;
   logic [3:0] idx_nxt;
   logic [3:0] idx_step;
   logic [3:0] start_idx;
   logic [3:0] lane;
   logic       done_nxt;
   logic       err_nxt;

   assign idx_step = idx + STEP;

   // Start index is 12 minus the round count.
   always_comb begin
      start_idx = 4'd0;
      unique case (nr)
         2'b00:   start_idx = 4'd0;
         2'b01:   start_idx = 4'd4;
         2'b10:   start_idx = 4'd6;
         default: start_idx = 4'd0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         idx   <= 4'd0;
         done  <= 1'b0;
         err   <= 1'b0;
      end else begin
         state <= state_nxt;
         idx   <= idx_nxt;
         done  <= done_nxt;
         err   <= err_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      done_nxt  = 1'b0;
      err_nxt   = 1'b0;
      if (clr) begin
         state_nxt = IDLE;
         idx_nxt   = 4'd0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  if (nr == 2'b11) begin
                     err_nxt = 1'b1;
                  end else begin
                     idx_nxt   = start_idx;
                     state_nxt = RUN;
                  end
               end
            end
            RUN: begin
               if (adv) begin
                  if (idx_step == LAST_IDX) begin
                     state_nxt = IDLE;
                     idx_nxt   = 4'd0;
                     done_nxt  = 1'b1;
                  end else begin
                     idx_nxt = idx_step;
                  end
               end
            end
            default: begin
               state_nxt = IDLE;
               idx_nxt   = 4'd0;
            end
         endcase
      end
   end

   always_comb begin
      busy = (state == RUN);
      last = busy && (idx_step == LAST_IDX);
      cst  = '0;
      lane = 4'd0;
      for (int k = 0; k < UNROLL; k++) begin
         lane = idx + 4'(k);
         if (busy) begin
            cst[8*k +: 8] = {4'hF - lane, lane};
         end
      end
   end

endmodule

// File: tb/tb_ascon_rcon_seq.sv
// Bench for ascon_rcon_seq: UNROLL=1 and UNROLL=2 instances share stimulus,
// each checked against a queue-of-remaining-rounds reference model.
module tb_ascon_rcon_seq;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [1:0]  nr = 2'b00;
   logic        adv = 1'b0;
   logic        clr = 1'b0;

   logic [7:0]  cst1;
   logic        busy1, last1, done1, err1;
   logic [15:0] cst2;
   logic        busy2, last2, done2, err2;

   int n_cmp = 0;
   int n_bad = 0;

   // Remaining rounds of the active permutation, per instance.
   int q1[$];
   int q2[$];
   logic done1_e, err1_e, done2_e, err2_e;

   always #5 clk = ~clk;

   ascon_rcon_seq #(.UNROLL(1)) u1 (
      .clk(clk), .rst_n(rst_n), .start(start), .nr(nr),
      .adv(adv), .clr(clr), .cst(cst1), .busy(busy1),
      .last(last1), .done(done1), .err(err1)
   );

   ascon_rcon_seq #(.UNROLL(2)) u2 (
      .clk(clk), .rst_n(rst_n), .start(start), .nr(nr),
      .adv(adv), .clr(clr), .cst(cst2), .busy(busy2),
      .last(last2), .done(done2), .err(err2)
   );

   function automatic logic [7:0] cval(input int i);
      cval = {4'(15 - i), 4'(i)};
   endfunction

   function automatic int rounds(input logic [1:0] m);
      case (m)
         2'b00:   rounds = 12;
         2'b01:   rounds = 8;
         default: rounds = 6;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [15:0] obs,
                      input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      q1.delete();
      q2.delete();
      done1_e = 1'b0; err1_e = 1'b0;
      done2_e = 1'b0; err2_e = 1'b0;
   endtask

   task automatic model_edge(input int u, inout int q[$],
                             output logic d, output logic e);
      d = 1'b0;
      e = 1'b0;
      if (clr) begin
         q.delete();
      end else if (q.size() == 0) begin
         if (start) begin
            if (nr == 2'b11) e = 1'b1;
            else for (int r = 12 - rounds(nr); r < 12; r++) q.push_back(r);
         end
      end else if (adv) begin
         for (int k = 0; k < u; k++) void'(q.pop_front());
         if (q.size() == 0) d = 1'b1;
      end
   endtask

   task automatic check_all(input string tag);
      logic [15:0] e1, e2;
      e1 = '0;
      e2 = '0;
      if (q1.size() > 0) e1 = {8'h00, cval(q1[0])};
      if (q2.size() > 0) e2 = {cval(q2[1]), cval(q2[0])};
      chk({tag, ".u1.cst"},  {8'h00, cst1}, e1);
      chk({tag, ".u1.busy"}, {15'd0, busy1}, {15'd0, q1.size() != 0});
      chk({tag, ".u1.last"}, {15'd0, last1}, {15'd0, q1.size() == 1});
      chk({tag, ".u1.done"}, {15'd0, done1}, {15'd0, done1_e});
      chk({tag, ".u1.err"},  {15'd0, err1},  {15'd0, err1_e});
      chk({tag, ".u2.cst"},  cst2, e2);
      chk({tag, ".u2.busy"}, {15'd0, busy2}, {15'd0, q2.size() != 0});
      chk({tag, ".u2.last"}, {15'd0, last2}, {15'd0, q2.size() == 2});
      chk({tag, ".u2.done"}, {15'd0, done2}, {15'd0, done2_e});
      chk({tag, ".u2.err"},  {15'd0, err2},  {15'd0, err2_e});
   endtask

   task automatic step(input string tag, input logic s, input logic [1:0] n,
                       input logic a, input logic c);
      start = s; nr = n; adv = a; clr = c;
      @(posedge clk);
      model_edge(1, q1, done1_e, err1_e);
      model_edge(2, q2, done2_e, err2_e);
      #1;
      check_all(tag);
   endtask

   initial begin
      model_reset();
      #12;
      check_all("reset");
      @(negedge clk);
      rst_n = 1'b1;
      step("idle", 1'b0, 2'b00, 1'b0, 1'b0);

      // p12 with adv high, plus literal first constants
      step("p12_start", 1'b1, 2'b00, 1'b1, 1'b0);
      chk("p12_first_u1", {8'h00, cst1}, 16'h00F0);
      chk("p12_first_u2", cst2, 16'hE1F0);
      for (int i = 0; i < 12; i++) step("p12_run", 1'b0, 2'b00, 1'b1, 1'b0);
      // back-to-back p8 in done cycle
      step("p8_start", 1'b1, 2'b01, 1'b1, 1'b0);
      chk("p8_first_u1", {8'h00, cst1}, 16'h00B4);
      for (int i = 0; i < 7; i++) step("p8_run", 1'b0, 2'b01, 1'b1, 1'b0);
      step("p6_start", 1'b1, 2'b10, 1'b1, 1'b0);
      chk("p6_first_u2", cst2, 16'h8796);
      for (int i = 0; i < 6; i++) step("p6_run", 1'b0, 2'b10, 1'b1, 1'b0);

      // stall at D2
      step("stall_start", 1'b1, 2'b00, 1'b1, 1'b0);
      step("stall_a", 1'b0, 2'b00, 1'b1, 1'b0);
      step("stall_b", 1'b0, 2'b00, 1'b1, 1'b0);
      chk("stall_at_d2", {8'h00, cst1}, 16'h00D2);
      for (int i = 0; i < 3; i++) step("stall_hold", 1'b0, 2'b00, 1'b0, 1'b0);
      chk("stall_hold_d2", {8'h00, cst1}, 16'h00D2);
      // ignored start of p8 while running
      step("ign_start", 1'b1, 2'b01, 1'b1, 1'b0);
      chk("resume_c3", {8'h00, cst1}, 16'h00C3);
      for (int i = 0; i < 2; i++) step("run_to_a5", 1'b0, 2'b00, 1'b1, 1'b0);
      chk("at_a5", {8'h00, cst1}, 16'h00A5);
      step("abort", 1'b1, 2'b01, 1'b1, 1'b1);
      chk("abort_busy", {15'd0, busy1}, 16'h0000);
      step("post_abort", 1'b0, 2'b00, 1'b0, 1'b0);

      // illegal mode, start held for two cycles
      step("illegal_a", 1'b1, 2'b11, 1'b0, 1'b0);
      chk("illegal_err", {15'd0, err1}, 16'h0001);
      step("illegal_b", 1'b1, 2'b11, 1'b0, 1'b0);
      step("illegal_end", 1'b0, 2'b00, 1'b0, 1'b0);

      // async reset mid-run at 87
      step("rst_start", 1'b1, 2'b00, 1'b1, 1'b0);
      for (int i = 0; i < 7; i++) step("rst_run", 1'b0, 2'b00, 1'b1, 1'b0);
      chk("at_87", {8'h00, cst1}, 16'h0087);
      rst_n = 1'b0;
      #1;
      model_reset();
      check_all("rst_async");
      @(negedge clk);
      rst_n = 1'b1;
      step("post_rst_p6", 1'b1, 2'b10, 1'b1, 1'b0);
      for (int i = 0; i < 6; i++) step("post_rst_run", 1'b0, 2'b00, 1'b1, 1'b0);

      // randomized
      for (int i = 0; i < 400; i++) begin
         step("rand", 1'($urandom_range(0, 3) == 0),
              2'($urandom_range(0, 3)),
              1'($urandom_range(0, 3) != 0),
              1'($urandom_range(0, 24) == 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/ascon_rcon_seq.md
# ascon_rcon_seq

Parametrised round-constant sequencer for the Ascon permutation datapath. It replaces the fixed single-mode constant generator. It supports all three permutation lengths (p12, p8, p6) and an unroll factor that emits several round constants per cycle. It adds a start/advance handshake with stall support, last/done signalling, a synchronous abort and illegal-mode rejection. It sits beside the round-function datapath and is driven by the mode-controller FSM.

## Interface
- UNROLL, 1: rounds per cycle; legal values 1 or 2 (both divide 12, 8, 6); any other value is an elaboration error.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin a permutation; honoured only in IDLE.
- nr  in  2  round count: 00 = 12, 01 = 8, 10 = 6, 11 = illegal.
- adv  in  1  datapath consumed current constant(s); advance.
- clr  in  1  synchronous abort; highest priority after reset.
- cst  out  8*UNROLL  round constants; lane k (bits 8k+7:8k) = round idx+k.
- busy  out  1  sequence active, cst valid.
- last  out  1  current cst contains the final round.
- done  out  1  one-cycle pulse after the final advance.
- err  out  1  one-cycle pulse: start with nr = 11.

## Operation
- State: FSM {IDLE, RUN}; 4-bit round index idx (0..11).
- Constant for round i: {4'hF - i, i[3:0]}, so 0xF0, 0xE1, … 0x4B. Lane k = {4'hF - (idx+k), idx+k}; 4-bit arithmetic, no wrap inside the legal range.
- Start index = 12 - nr_rounds: p12 → 0, p8 → 4, p6 → 6.
- IDLE, start = 1, nr ≠ 11: load idx, go to RUN.
- IDLE, start = 1, nr = 11: stay IDLE; err = 1 next cycle.
- RUN, adv = 0: hold idx and cst (stall).
- RUN, adv = 1, idx + UNROLL < 12: idx += UNROLL.
- RUN, adv = 1, idx + UNROLL = 12: go to IDLE; done = 1 next cycle.
- start in RUN is ignored; no err.
- clr = 1 in any state: next cycle IDLE, idx = 0, no done, no err. clr wins over simultaneous start or adv.
- Outputs are registered or decoded from registered state only; no combinational path from inputs to outputs.
- cst = 0 whenever busy = 0.
- last = busy & (idx + UNROLL == 12).

## Timing
- Reset (rst_n = 0, asynchronous): IDLE, idx = 0, cst = 0, busy = 0, last = 0, done = 0, err = 0. Release is synchronous to the next clk edge.
- Start latency: start sampled at edge N; busy = 1 and cst = first constant from edge N (visible in cycle N+1).
- Throughput: one constant group per cycle while adv = 1.
- Cycles in RUN with adv held high: nr_rounds / UNROLL (p12/U1 = 12, p8/U2 = 4).
- done asserts in the cycle after the final adv, with busy = 0. A new start is accepted in that same cycle.
- err pulses for exactly one cycle per illegal start; start held high with nr = 11 pulses err every cycle.
- Reset asserted mid-RUN: all outputs go to reset values immediately (asynchronous). No done pulse.

## Test plan
- p12, UNROLL = 1, adv held high: cst = F0, E1, D2, C3, B4, A5, 96, 87, 78, 69, 5A, 4B on consecutive cycles. last only on 4B; done one cycle after; busy high for 12 cycles.
- p8 and p6, UNROLL = 1: p8 sequence B4…4B (8 cycles); p6 sequence 96…4B (6 cycles). Back-to-back start in the done cycle restarts at the correct constant.
- UNROLL = 2, p12: cst = E1F0, C3D2, A5B4, 8796, 6978, 4B5A; last on 4B5A. p6 yields 8796, 6978, 4B5A.
- Stall: p12/U1, adv = 0 for 3 cycles at D2 → cst holds D2, busy = 1, last = 0; sequence then resumes at C3 with no skipped or repeated constant.
- Abort and reset: clr at constant A5 → next cycle busy = 0, cst = 0, no done. rst_n low mid-RUN at 87 → outputs 0 immediately; after release, start works normally.
- Illegal mode and ignored start: start with nr = 11 in IDLE → err pulse, busy stays 0. start with nr = 01 during p12 RUN → ignored, p12 sequence completes unchanged.
